// File: rtl/atm_if.sv
// User-facing signal bundle of the ATM terminal: keypad/card inputs in, one-cycle status pulses out.
interface atm_if;
   logic        Card_in;
   logic        Language;
   logic        Timer;
   logic        money_counting;
   logic        another_transaction_bit;
   logic [2:0]  opcode;
   logic [16:0] password;
   logic [16:0] new_pin;
   logic        allowwithdraw;
   logic        take_receipt;
   logic        allow_transfer;
   logic [16:0] Pers_Account_No;
   logic [16:0] ur_account;
   logic [18:0] withdraw_amount;
   logic [18:0] Transfer_Amount;
   logic [18:0] deposit_amount;
   logic        Transfer_Successfully;
   logic        ATM_Usage_Finished;
   logic        Balance_Shown;
   logic        Deposited_Successfully;
   logic        Withdrew_Successfully;
   logic        Pin_Changed_Successfully;
   logic        Receipt_Printed;
   logic        Lang_Latched;

   modport slave (
      input  Card_in, Language, Timer, money_counting, another_transaction_bit,
             opcode, password, new_pin, allowwithdraw, take_receipt, allow_transfer,
             Pers_Account_No, ur_account, withdraw_amount, Transfer_Amount, deposit_amount,
      output Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
             Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
             Receipt_Printed, Lang_Latched
   );

   modport master (
      output Card_in, Language, Timer, money_counting, another_transaction_bit,
             opcode, password, new_pin, allowwithdraw, take_receipt, allow_transfer,
             Pers_Account_No, ur_account, withdraw_amount, Transfer_Amount, deposit_amount,
      input  Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
             Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
             Receipt_Printed, Lang_Latched
   );
endinterface

// File: rtl/atm.sv
// Single-terminal ATM session controller with an internal account/PIN/balance table.
// One transition per clock; every completed operation is reported as a registered one-cycle pulse.
module atm #(
   parameter int          NUM_ACCTS = 4,
   parameter logic [16:0] ACCT_BASE = 17'd1000,
   parameter logic [16:0] PIN_BASE  = 17'd1234,
   parameter logic [18:0] INIT_BAL  = 19'd5000,
   parameter int          MAX_TRIES = 3
) (
   input  logic  clk,
   input  logic  reset,
   atm_if.slave  bus
);

   localparam int IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LANG, S_PIN, S_MENU, S_BAL, S_WDR,
      S_DEP, S_XFER, S_CHPIN, S_RCPT, S_ANOTHER, S_FINISH
   } AtmState;

   AtmState           r_state;
   AtmState           w_next;
   logic [IDX_W-1:0]  r_idx;
   logic [TRY_W-1:0]  r_tries;
   logic              r_lang;
   logic [16:0]       r_pin [NUM_ACCTS];
   logic [18:0]       r_bal [NUM_ACCTS];

   logic r_xferDone, r_finDone, r_balShown, r_depDone, r_wdrDone, r_pinDone, r_rcptDone;
   logic w_xferDone, w_finDone, w_balShown, w_depDone, w_wdrDone, w_pinDone, w_rcptDone;

   logic              w_cardHit, w_dstHit;
   logic [IDX_W-1:0]  w_cardIdx, w_dstIdx;
   logic [18:0]       w_ownBal, w_dstBal;
   logic [19:0]       w_depSum, w_xferSum;
   logic              w_wdrOk, w_depOk, w_xferOk, w_abort;
   logic [TRY_W-1:0]  w_triesInc, w_triesNext;
   logic              w_loadIdx, w_loadLang;
   logic              w_ownWe, w_dstWe, w_pinWe;
   logic [18:0]       w_ownNew, w_dstNew;

   // Account numbers are fixed at ACCT_BASE+i, so lookup is a compare against constants.
   always_comb begin
      w_cardHit = 1'b0;
      w_cardIdx = '0;
      w_dstHit  = 1'b0;
      w_dstIdx  = '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
         if (bus.Pers_Account_No == ACCT_BASE + 17'(i)) begin
            w_cardHit = 1'b1;
            w_cardIdx = IDX_W'(i);
         end
         if (bus.ur_account == ACCT_BASE + 17'(i)) begin
            w_dstHit = 1'b1;
            w_dstIdx = IDX_W'(i);
         end
      end
   end

   assign w_ownBal   = r_bal[r_idx];
   assign w_dstBal   = r_bal[w_dstIdx];
   assign w_depSum   = {1'b0, w_ownBal} + {1'b0, bus.deposit_amount};
   assign w_xferSum  = {1'b0, w_dstBal} + {1'b0, bus.Transfer_Amount};
   assign w_dstNew   = w_xferSum[18:0];
   assign w_triesInc = r_tries + TRY_W'(1);

   assign w_wdrOk  = bus.allowwithdraw && (bus.withdraw_amount != 19'd0)
                     && (bus.withdraw_amount <= w_ownBal);
   assign w_depOk  = !w_depSum[19] && (bus.deposit_amount != 19'd0);
   assign w_xferOk = bus.allow_transfer && w_dstHit && (w_dstIdx != r_idx)
                     && (bus.Transfer_Amount != 19'd0)
                     && (bus.Transfer_Amount <= w_ownBal) && !w_xferSum[19];

   assign w_abort = (r_state != S_IDLE) && (r_state != S_FINISH) && (bus.Timer || !bus.Card_in);

   always_comb begin
      w_next      = r_state;
      w_triesNext = r_tries;
      w_loadIdx   = 1'b0;
      w_loadLang  = 1'b0;
      w_ownWe     = 1'b0;
      w_ownNew    = w_ownBal;
      w_dstWe     = 1'b0;
      w_pinWe     = 1'b0;
      w_xferDone  = 1'b0;
      w_finDone   = 1'b0;
      w_balShown  = 1'b0;
      w_depDone   = 1'b0;
      w_wdrDone   = 1'b0;
      w_pinDone   = 1'b0;
      w_rcptDone  = 1'b0;
      if (w_abort) begin
         w_next = S_FINISH;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Card_in && w_cardHit) begin
                  w_loadIdx = 1'b1;
                  w_next    = S_LANG;
               end
            end
            S_LANG: begin
               w_loadLang = 1'b1;
               w_next     = S_PIN;
            end
            S_PIN: begin
               if (bus.password == r_pin[r_idx]) begin
                  w_triesNext = '0;
                  w_next      = S_MENU;
               end else begin
                  w_triesNext = w_triesInc;
                  if (w_triesInc >= TRY_W'(MAX_TRIES)) w_next = S_FINISH;
               end
            end
            S_MENU: begin
               case (bus.opcode)
                  3'b001:  w_next = S_BAL;
                  3'b010:  w_next = S_WDR;
                  3'b011:  w_next = S_DEP;
                  3'b100:  w_next = S_XFER;
                  3'b101:  w_next = S_CHPIN;
                  default: w_next = S_MENU;
               endcase
            end
            S_BAL: begin
               w_balShown = 1'b1;
               w_next     = S_RCPT;
            end
            S_WDR: begin
               if (w_wdrOk) begin
                  w_ownWe   = 1'b1;
                  w_ownNew  = w_ownBal - bus.withdraw_amount;
                  w_wdrDone = 1'b1;
               end
               w_next = S_RCPT;
            end
            S_DEP: begin
               // Cash is still being counted: hold here until the total is final.
               if (!bus.money_counting) begin
                  if (w_depOk) begin
                     w_ownWe   = 1'b1;
                     w_ownNew  = w_depSum[18:0];
                     w_depDone = 1'b1;
                  end
                  w_next = S_RCPT;
               end
            end
            S_XFER: begin
               if (w_xferOk) begin
                  w_ownWe    = 1'b1;
                  w_ownNew   = w_ownBal - bus.Transfer_Amount;
                  w_dstWe    = 1'b1;
                  w_xferDone = 1'b1;
               end
               w_next = S_RCPT;
            end
            S_CHPIN: begin
               w_pinWe   = 1'b1;
               w_pinDone = 1'b1;
               w_next    = S_RCPT;
            end
            S_RCPT: begin
               w_rcptDone = bus.take_receipt;
               w_next     = S_ANOTHER;
            end
            S_ANOTHER: begin
               w_next = bus.another_transaction_bit ? S_MENU : S_FINISH;
            end
            S_FINISH: begin
               w_finDone   = 1'b1;
               w_triesNext = '0;
               w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_tries    <= '0;
         r_lang     <= 1'b0;
         r_xferDone <= 1'b0;
         r_finDone  <= 1'b0;
         r_balShown <= 1'b0;
         r_depDone  <= 1'b0;
         r_wdrDone  <= 1'b0;
         r_pinDone  <= 1'b0;
         r_rcptDone <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_tries    <= w_triesNext;
         if (w_loadIdx)  r_idx  <= w_cardIdx;
         if (w_loadLang) r_lang <= bus.Language;
         r_xferDone <= w_xferDone;
         r_finDone  <= w_finDone;
         r_balShown <= w_balShown;
         r_depDone  <= w_depDone;
         r_wdrDone  <= w_wdrDone;
         r_pinDone  <= w_pinDone;
         r_rcptDone <= w_rcptDone;
      end
   end

   // Source and destination of a transfer are distinct entries, so both updates land on one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ACCTS; i++) begin
            r_pin[i] <= PIN_BASE + 17'(i);
            r_bal[i] <= INIT_BAL;
         end
      end else begin
         for (int i = 0; i < NUM_ACCTS; i++) begin
            if (w_ownWe && (r_idx == IDX_W'(i))) begin
               r_bal[i] <= w_ownNew;
            end else if (w_dstWe && (w_dstIdx == IDX_W'(i))) begin
               r_bal[i] <= w_dstNew;
            end
            if (w_pinWe && (r_idx == IDX_W'(i))) r_pin[i] <= bus.new_pin;
         end
      end
   end

   assign bus.Transfer_Successfully    = r_xferDone;
   assign bus.ATM_Usage_Finished       = r_finDone;
   assign bus.Balance_Shown            = r_balShown;
   assign bus.Deposited_Successfully   = r_depDone;
   assign bus.Withdrew_Successfully    = r_wdrDone;
   assign bus.Pin_Changed_Successfully = r_pinDone;
   assign bus.Receipt_Printed          = r_rcptDone;
   assign bus.Lang_Latched             = r_lang;

endmodule

// File: tb/tb_atm.sv
// Directed self-checking bench for the ATM session controller; balances are observed indirectly
// through which later withdrawals/transfers are accepted.
module tb_atm;
   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_XFER = 7'b1000000;
   localparam logic [6:0] O_FIN  = 7'b0100000;
   localparam logic [6:0] O_BAL  = 7'b0010000;
   localparam logic [6:0] O_DEP  = 7'b0001000;
   localparam logic [6:0] O_WDR  = 7'b0000100;
   localparam logic [6:0] O_PIN  = 7'b0000010;
   localparam logic [6:0] O_RCPT = 7'b0000001;

   localparam logic [2:0] OP_BAL = 3'b001;
   localparam logic [2:0] OP_WDR = 3'b010;
   localparam logic [2:0] OP_DEP = 3'b011;
   localparam logic [2:0] OP_XFR = 3'b100;
   localparam logic [2:0] OP_CHP = 3'b101;

   logic clk = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   atm_if bus();

   atm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wire [6:0] outs = {bus.Transfer_Successfully, bus.ATM_Usage_Finished, bus.Balance_Shown,
                      bus.Deposited_Successfully, bus.Withdrew_Successfully,
                      bus.Pin_Changed_Successfully, bus.Receipt_Printed};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.Card_in = 0; bus.Language = 0; bus.Timer = 0; bus.money_counting = 0;
      bus.another_transaction_bit = 0; bus.opcode = 0; bus.password = 0; bus.new_pin = 0;
      bus.allowwithdraw = 0; bus.take_receipt = 0; bus.allow_transfer = 0;
      bus.Pers_Account_No = 0; bus.ur_account = 0; bus.withdraw_amount = 0;
      bus.Transfer_Amount = 0; bus.deposit_amount = 0;
   endtask

   task automatic doReset();
      clearInputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // IDLE -> LANG -> PIN -> (MENU when the PIN is right)
   task automatic login(input logic [16:0] acct, input logic [16:0] pin);
      bus.Card_in = 1; bus.Timer = 0; bus.Pers_Account_No = acct; bus.password = pin;
      tick(); tick(); tick();
   endtask

   // From MENU: op state, RCPT, ANOTHER, then MENU or FINISH. Receipt is declined.
   task automatic runOp(input logic [2:0] op, input logic another,
                        output logic [6:0] pulse, output logic [6:0] other);
      bus.opcode = op; bus.take_receipt = 0; bus.money_counting = 0;
      bus.another_transaction_bit = another;
      tick(); other = outs;
      tick(); pulse = outs;
      tick(); other |= outs;
      tick(); other |= outs;
   endtask

   task automatic finishSession(output logic [6:0] fin);
      tick(); fin = outs;
      bus.Card_in = 0;
      tick();
   endtask

   task automatic oneOpSession(input logic [16:0] acct, input logic [16:0] pin, input logic [2:0] op,
                               output logic [6:0] pulse, output logic [6:0] other,
                               output logic [6:0] fin);
      login(acct, pin);
      runOp(op, 1'b0, pulse, other);
      finishSession(fin);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clearInputs();
      #2;
      bus.Card_in = 1'($urandom); bus.Timer = 1'($urandom); bus.opcode = 3'($urandom);
      bus.password = 17'($urandom); bus.Pers_Account_No = 17'd1000 + 17'($urandom_range(0, 3));
      bus.take_receipt = 1'($urandom); bus.Language = 1'($urandom);
      reset = 1'b0;
      #1;
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL reset_async: got %b expected %b", outs, O_NONE);
      end
      tick(); tick();
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL reset_held: got %b expected %b", outs, O_NONE);
      end
      compared++;
      if (bus.Lang_Latched !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_lang: got %b expected 0", bus.Lang_Latched);
      end
      clearInputs();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         compared++;
         if (outs !== O_NONE) begin
            mismatched++; $display("[TB] FAIL idle_nocard[%0d]: got %b expected %b", k, outs, O_NONE);
         end
      end
   endtask

   task automatic test_balance_session();
      logic [6:0] exp [5] = '{O_NONE, O_BAL, O_RCPT, O_NONE, O_FIN};
      doReset();
      bus.Language = 1;
      login(17'd1001, 17'd1235);
      compared++;
      if (bus.Lang_Latched !== 1'b1) begin
         mismatched++; $display("[TB] FAIL lang_latch: got %b expected 1", bus.Lang_Latched);
      end
      bus.opcode = 3'b000; tick();
      bus.opcode = 3'b111; tick();
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL bad_opcode: got %b expected %b", outs, O_NONE);
      end
      bus.opcode = OP_BAL; bus.take_receipt = 1; bus.another_transaction_bit = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         compared++;
         if (outs !== exp[k]) begin
            mismatched++; $display("[TB] FAIL bal_session[%0d]: got %b expected %b", k, outs, exp[k]);
         end
      end
      bus.Card_in = 0; bus.Language = 0;
      tick();
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL bal_idle_after: got %b expected %b", outs, O_NONE);
      end
   endtask

   task automatic test_withdraw();
      logic [18:0] amt   [6] = '{19'd2000, 19'd4000, 19'd0, 19'd100, 19'd3000, 19'd1};
      logic        allow [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [6:0]  exp   [6] = '{O_WDR, O_NONE, O_NONE, O_NONE, O_WDR, O_NONE};
      logic [6:0]  p, o, f;
      doReset();
      login(17'd1000, 17'd1234);
      for (int k = 0; k < 6; k++) begin
         bus.withdraw_amount = amt[k]; bus.allowwithdraw = allow[k];
         runOp(OP_WDR, k < 5, p, o);
         compared++;
         if (p !== exp[k]) begin
            mismatched++; $display("[TB] FAIL wdr_pulse[%0d]: got %b expected %b", k, p, exp[k]);
         end
         compared++;
         if (o !== O_NONE) begin
            mismatched++; $display("[TB] FAIL wdr_quiet[%0d]: got %b expected %b", k, o, O_NONE);
         end
      end
      finishSession(f);
      compared++;
      if (f !== O_FIN) begin
         mismatched++; $display("[TB] FAIL wdr_finish: got %b expected %b", f, O_FIN);
      end
   endtask

   task automatic test_deposit();
      logic [2:0]  op  [6] = '{OP_WDR, OP_WDR, OP_DEP, OP_DEP, OP_DEP, OP_WDR};
      logic [18:0] amt [6] = '{19'd5701, 19'd5700, 19'd524287, 19'd1, 19'd0, 19'd524287};
      logic [6:0]  exp [6] = '{O_NONE, O_WDR, O_DEP, O_NONE, O_NONE, O_WDR};
      logic [6:0]  p, o, f;
      doReset();
      login(17'd1001, 17'd1235);
      bus.opcode = OP_DEP; bus.deposit_amount = 19'd700; bus.money_counting = 1;
      bus.another_transaction_bit = 1; bus.take_receipt = 0;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         compared++;
         if (outs !== O_NONE) begin
            mismatched++; $display("[TB] FAIL dep_counting[%0d]: got %b expected %b", k, outs, O_NONE);
         end
      end
      bus.money_counting = 0;
      tick();
      compared++;
      if (outs !== O_DEP) begin
         mismatched++; $display("[TB] FAIL dep_700: got %b expected %b", outs, O_DEP);
      end
      tick(); tick();
      bus.allowwithdraw = 1;
      for (int k = 0; k < 6; k++) begin
         bus.withdraw_amount = amt[k]; bus.deposit_amount = amt[k];
         runOp(op[k], k < 5, p, o);
         compared++;
         if (p !== exp[k]) begin
            mismatched++; $display("[TB] FAIL dep_seq[%0d]: got %b expected %b", k, p, exp[k]);
         end
      end
      finishSession(f);
      compared++;
      if (f !== O_FIN) begin
         mismatched++; $display("[TB] FAIL dep_finish: got %b expected %b", f, O_FIN);
      end
   endtask

   task automatic test_transfer();
      logic [16:0] dst   [6] = '{17'd1002, 17'd1000, 17'd1005, 17'd1001, 17'd1001, 17'd1001};
      logic [18:0] amt   [6] = '{19'd1000, 19'd100, 19'd100, 19'd100, 19'd0, 19'd4001};
      logic        allow [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [6:0]  exp   [6] = '{O_XFER, O_NONE, O_NONE, O_NONE, O_NONE, O_NONE};
      logic [6:0]  p, o, f;
      doReset();
      login(17'd1000, 17'd1234);
      for (int k = 0; k < 6; k++) begin
         bus.ur_account = dst[k]; bus.Transfer_Amount = amt[k]; bus.allow_transfer = allow[k];
         runOp(OP_XFR, k < 5, p, o);
         compared++;
         if (p !== exp[k]) begin
            mismatched++; $display("[TB] FAIL xfer[%0d]: got %b expected %b", k, p, exp[k]);
         end
      end
      finishSession(f);
      bus.allowwithdraw = 1;
      login(17'd1002, 17'd1236);
      bus.withdraw_amount = 19'd6001; runOp(OP_WDR, 1'b1, p, o);
      compared++;
      if (p !== O_NONE) begin
         mismatched++; $display("[TB] FAIL xfer_dst_6001: got %b expected %b", p, O_NONE);
      end
      bus.withdraw_amount = 19'd6000; runOp(OP_WDR, 1'b0, p, o);
      compared++;
      if (p !== O_WDR) begin
         mismatched++; $display("[TB] FAIL xfer_dst_6000: got %b expected %b", p, O_WDR);
      end
      finishSession(f);
      login(17'd1000, 17'd1234);
      bus.withdraw_amount = 19'd4001; runOp(OP_WDR, 1'b1, p, o);
      compared++;
      if (p !== O_NONE) begin
         mismatched++; $display("[TB] FAIL xfer_src_4001: got %b expected %b", p, O_NONE);
      end
      bus.withdraw_amount = 19'd4000; runOp(OP_WDR, 1'b0, p, o);
      compared++;
      if (p !== O_WDR) begin
         mismatched++; $display("[TB] FAIL xfer_src_4000: got %b expected %b", p, O_WDR);
      end
      finishSession(f);
      bus.deposit_amount = 19'd519287;
      oneOpSession(17'd1001, 17'd1235, OP_DEP, p, o, f);
      compared++;
      if (p !== O_DEP) begin
         mismatched++; $display("[TB] FAIL xfer_fill_dep: got %b expected %b", p, O_DEP);
      end
      login(17'd1003, 17'd1237);
      bus.allow_transfer = 1; bus.ur_account = 17'd1001; bus.Transfer_Amount = 19'd1;
      runOp(OP_XFR, 1'b1, p, o);
      compared++;
      if (p !== O_NONE) begin
         mismatched++; $display("[TB] FAIL xfer_dst_overflow: got %b expected %b", p, O_NONE);
      end
      bus.ur_account = 17'd1002; bus.Transfer_Amount = 19'd5000;
      runOp(OP_XFR, 1'b0, p, o);
      compared++;
      if (p !== O_XFER) begin
         mismatched++; $display("[TB] FAIL xfer_full_bal: got %b expected %b", p, O_XFER);
      end
      finishSession(f);
   endtask

   task automatic test_wrong_pin();
      logic [6:0] exp [6] = '{O_NONE, O_NONE, O_NONE, O_NONE, O_NONE, O_FIN};
      logic [6:0] p, o, f;
      doReset();
      bus.Card_in = 1; bus.Pers_Account_No = 17'd1002; bus.password = 17'd9999; bus.opcode = OP_BAL;
      for (int k = 0; k < 6; k++) begin
         tick();
         compared++;
         if (outs !== exp[k]) begin
            mismatched++; $display("[TB] FAIL wrong_pin[%0d]: got %b expected %b", k, outs, exp[k]);
         end
      end
      bus.Card_in = 0;
      tick();
      bus.Card_in = 1;
      tick(); tick(); tick(); tick();
      bus.password = 17'd1236;
      tick();
      runOp(OP_BAL, 1'b0, p, o);
      compared++;
      if (p !== O_BAL) begin
         mismatched++; $display("[TB] FAIL pin_third_try: got %b expected %b", p, O_BAL);
      end
      finishSession(f);
      compared++;
      if (f !== O_FIN) begin
         mismatched++; $display("[TB] FAIL pin_third_finish: got %b expected %b", f, O_FIN);
      end
   endtask

   task automatic test_change_pin();
      logic [6:0] p, o, f;
      doReset();
      bus.new_pin = 17'd42;
      oneOpSession(17'd1003, 17'd1237, OP_CHP, p, o, f);
      compared++;
      if (p !== O_PIN) begin
         mismatched++; $display("[TB] FAIL chpin_pulse: got %b expected %b", p, O_PIN);
      end
      compared++;
      if (f !== O_FIN) begin
         mismatched++; $display("[TB] FAIL chpin_finish: got %b expected %b", f, O_FIN);
      end
      oneOpSession(17'd1003, 17'd42, OP_BAL, p, o, f);
      compared++;
      if (p !== O_BAL) begin
         mismatched++; $display("[TB] FAIL chpin_relogin: got %b expected %b", p, O_BAL);
      end
   endtask

   task automatic test_abort();
      logic [6:0] p, o, f;
      doReset();
      login(17'd1000, 17'd1234);
      bus.opcode = OP_WDR; bus.allowwithdraw = 1; bus.withdraw_amount = 19'd100;
      tick();
      bus.Timer = 1;
      tick();
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL abort_timer_wdr: got %b expected %b", outs, O_NONE);
      end
      bus.Timer = 0;
      tick();
      compared++;
      if (outs !== O_FIN) begin
         mismatched++; $display("[TB] FAIL abort_timer_fin: got %b expected %b", outs, O_FIN);
      end
      bus.Card_in = 0;
      tick();
      bus.Card_in = 1; bus.Pers_Account_No = 17'd1001; bus.password = 17'd1235;
      tick(); tick();
      bus.Card_in = 0;
      tick();
      compared++;
      if (outs !== O_NONE) begin
         mismatched++; $display("[TB] FAIL abort_card_pin: got %b expected %b", outs, O_NONE);
      end
      tick();
      compared++;
      if (outs !== O_FIN) begin
         mismatched++; $display("[TB] FAIL abort_card_fin: got %b expected %b", outs, O_FIN);
      end
      bus.withdraw_amount = 19'd5000;
      oneOpSession(17'd1000, 17'd1234, OP_WDR, p, o, f);
      compared++;
      if (p !== O_WDR) begin
         mismatched++; $display("[TB] FAIL abort_no_debit: got %b expected %b", p, O_WDR);
      end
      login(17'd1002, 17'd1236);
      bus.withdraw_amount = 19'd5000;
      runOp(OP_WDR, 1'b1, p, o);
      doReset();
      bus.allowwithdraw = 1; bus.withdraw_amount = 19'd5000;
      oneOpSession(17'd1002, 17'd1236, OP_WDR, p, o, f);
      compared++;
      if (p !== O_WDR) begin
         mismatched++; $display("[TB] FAIL reset_restores_bal: got %b expected %b", p, O_WDR);
      end
   endtask

   initial begin
      test_reset();
      test_balance_session();
      test_withdraw();
      test_deposit();
      test_transfer();
      test_wrong_pin();
      test_change_pin();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
